// File: rtl/noc_pkg.sv
// Shared NoC constants, checker FSM encoding and a saturating counter helper.
// Pure definitions with no latency and no backpressure.
// Imported by packet_checker and seq_table.
package noc_pkg;

    localparam int FLIT_W   = 8;
    localparam int SRC_BITS = 3;
    localparam int CHANNELS = 5;
    localparam int SEQ_W    = 8;

    typedef enum logic [1:0] {
        HEAD   = 2'd0,
        BODY   = 2'd1,
        REPORT = 2'd2
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

endpackage

// File: rtl/seq_table.sv
// Per-source expected sequence numbers, one 8-bit entry for each of CHANNELS sources.
// Latency: combinational read by source, write lands on the next rising edge.
// Backpressure: none; the owner decides when to write.
module seq_table
    import noc_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [SRC_BITS-1:0] i_rd_src,
    output logic [SEQ_W-1:0]    o_rd_exp,
    output logic                o_rd_vld,
    input  logic                i_wr_en,
    input  logic [SRC_BITS-1:0] i_wr_src,
    input  logic [SEQ_W-1:0]    i_wr_dat
);

    logic [SEQ_W-1:0] r_exp [CHANNELS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_exp[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (i_wr_en && (i_wr_src == SRC_BITS'(i))) begin
                    r_exp[i] <= i_wr_dat;
                end
            end
        end
    end

    // Source IDs beyond the table have no entry and are reported as not valid.
    always_comb begin
        o_rd_exp = '0;
        o_rd_vld = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (i_rd_src == SRC_BITS'(i)) begin
                o_rd_exp = r_exp[i];
                o_rd_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/packet_checker.sv
// Packet checker: destination match and tail XOR checksum; PKT_CHECK_SEQ_EN adds per-source sequence checking.
// Latency: pkt_done pulses one cycle after the tail transfer; counters update at the end of that cycle.
// Backpressure: registered ch_ack, at most one flit every two cycles; never acks during REPORT.
module packet_checker
    import noc_pkg::*;
#(
    parameter int ID               = 1,
    parameter int DESTINATION_BITS = 1,
    parameter int FLITS            = 8,
    parameter int SIZE             = FLIT_W
)(
    input  logic                clk,
    input  logic                reset,
    input  logic                ch_req,
    input  logic [SIZE-1:0]     ch_flit,
    output logic                ch_ack,
    output logic                pkt_done,
    output logic                pkt_err,
    output logic [SRC_BITS-1:0] pkt_src,
    output logic [15:0]         pkt_count,
    output logic [15:0]         err_count
);

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] TAIL_IDX = CNT_W'(FLITS - 1);
    localparam logic [DESTINATION_BITS-1:0] OWN_DEST = DESTINATION_BITS'(ID);

    state_t r_state;
    state_t w_state_nxt;

    logic                r_ack;
    logic                r_done;
    logic                r_err;
    logic [SRC_BITS-1:0] r_src;
    logic                r_dest_ok;
    logic [SIZE-1:0]     r_xor;
    logic [CNT_W-1:0]    r_cnt;
    logic [15:0]         r_pkt_cnt;
    logic [15:0]         r_err_cnt;

    logic w_ack_nxt;
    logic w_done_nxt;
    logic w_rpt;
    logic w_xfer;
    logic w_tail;
    logic w_cks_err;
    logic w_seq_err;

    assign w_xfer    = ch_req & r_ack;
    assign w_tail    = (r_cnt == TAIL_IDX);
    assign w_cks_err = (ch_flit != r_xor);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= HEAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The ack is only offered when it was low last cycle, which enforces the idle gap.
    always_comb begin
        w_state_nxt = r_state;
        w_ack_nxt   = 1'b0;
        w_done_nxt  = 1'b0;
        w_rpt       = 1'b0;
        unique case (r_state)
            HEAD: begin
                w_ack_nxt = ch_req & ~r_ack;
                if (w_xfer) begin
                    w_state_nxt = BODY;
                end
            end
            BODY: begin
                w_ack_nxt = ch_req & ~r_ack;
                if (w_xfer && w_tail) begin
                    w_state_nxt = REPORT;
                    w_done_nxt  = 1'b1;
                end
            end
            REPORT: begin
                w_rpt       = 1'b1;
                w_state_nxt = HEAD;
            end
            default: begin
                w_state_nxt = HEAD;
            end
        endcase
    end

`ifdef PKT_CHECK_SEQ_EN
    logic [SEQ_W-1:0] r_seq_rx;
    logic [SEQ_W-1:0] w_seq_exp;
    logic             w_seq_vld;

    seq_table u_seq_table (
        .clk      (clk),
        .reset    (reset),
        .i_rd_src (r_src),
        .o_rd_exp (w_seq_exp),
        .o_rd_vld (w_seq_vld),
        .i_wr_en  (w_rpt),
        .i_wr_src (r_src),
        .i_wr_dat (r_seq_rx + SEQ_W'(1))
    );

    // Sources without a table entry are not sequence checked.
    assign w_seq_err = w_seq_vld && (r_seq_rx != w_seq_exp);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_seq_rx <= '0;
        end else if ((r_state == BODY) && w_xfer && (r_cnt == CNT_W'(1))) begin
            r_seq_rx <= ch_flit[SEQ_W-1:0];
        end
    end
`else
    assign w_seq_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ack     <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_src     <= '0;
            r_dest_ok <= 1'b0;
            r_xor     <= '0;
            r_cnt     <= '0;
            r_pkt_cnt <= '0;
            r_err_cnt <= '0;
        end else begin
            r_ack  <= w_ack_nxt;
            r_done <= w_done_nxt;
            r_err  <= w_done_nxt & (~r_dest_ok | w_cks_err | w_seq_err);
            if ((r_state == HEAD) && w_xfer) begin
                r_src     <= ch_flit[SIZE-1 -: SRC_BITS];
                r_dest_ok <= (ch_flit[DESTINATION_BITS-1:0] == OWN_DEST);
                r_xor     <= '0;
                r_cnt     <= CNT_W'(1);
            end else if ((r_state == BODY) && w_xfer) begin
                if (!w_tail) begin
                    r_xor <= r_xor ^ ch_flit;
                end
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_rpt) begin
                r_pkt_cnt <= sat_inc16(r_pkt_cnt, 1'b1);
                r_err_cnt <= sat_inc16(r_err_cnt, r_err);
            end
        end
    end

    assign ch_ack    = r_ack;
    assign pkt_done  = r_done;
    assign pkt_err   = r_err;
    assign pkt_src   = r_src;
    assign pkt_count = r_pkt_cnt;
    assign err_count = r_err_cnt;

endmodule
